// File: rtl/div_iter_pkg.sv
// ----------------------------------------------------------------------------
// div_iter_pkg
// Shared definitions for the EX-stage iterative divider: FSM state encoding,
// default operand width, iteration count and counter-width helper.
// Optional feature macro: DIV_SHORTCUT_EN (adds the SHORT state).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package div_iter_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
`ifdef DIV_SHORTCUT_EN
    S_SHORT = 2'd2,
`endif
    S_DONE  = 2'd3
  } div_state_t;

  // Counter must hold 0..w-1, one value per quotient bit.
  function automatic int div_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_ITERS);

endpackage

`default_nettype wire

// File: rtl/div_sign_fix.sv
// ----------------------------------------------------------------------------
// div_sign_fix
// Conditional two's-complement negation of two WIDTH-bit values. Used on the
// input side to take operand magnitudes and on the output side to apply the
// quotient/remainder signs.
// Ports:
//   x, y         in  WIDTH  values to fix
//   neg_x, neg_y in  1      negate the corresponding value when set
//   x_fix, y_fix out WIDTH  fixed values
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg_x,
  input  logic [WIDTH-1:0] y,
  input  logic             neg_y,
  output logic [WIDTH-1:0] x_fix,
  output logic [WIDTH-1:0] y_fix
);

  assign x_fix = neg_x ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  assign y_fix = neg_y ? (~y + {{(WIDTH-1){1'b0}}, 1'b1}) : y;

endmodule

`default_nettype wire

// File: rtl/div_iter.sv
// ----------------------------------------------------------------------------
// div_iter
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage. Produces
// {remainder, quotient} for {HI, LO} and raises stall_o while a division is
// in flight. Honours the pipeline flush (annul_i) and downstream stall
// (hold_i) so a finished result is held until EX advances.
// Optional feature macro: DIV_SHORTCUT_EN - divisor zero or larger than the
// dividend resolves in a single SHORT cycle with bit-identical results.
// Ports:
//   clk       in  1        rising-edge clock
//   resetn    in  1        asynchronous active-low reset
//   start_i   in  1        valid DIV/DIVU in EX (held until it leaves EX)
//   signed_i  in  1        1 = DIV, 0 = DIVU (sampled at start)
//   opa_i     in  WIDTH    dividend (sampled at start)
//   opb_i     in  WIDTH    divisor (sampled at start)
//   annul_i   in  1        exception flush, abandons any division
//   hold_i    in  1        downstream stall, keeps a finished result
//   result_o  out 2*WIDTH  {remainder, quotient}
//   ready_o   out 1        result_o valid
//   stall_o   out 1        EX must stall
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  input  logic               hold_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  localparam int             CNT_W    = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;     // partial remainder
  logic [WIDTH-1:0] quo;     // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] dvsr;    // divisor magnitude
  logic             sign_a;
  logic             sign_b;

  logic             accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] fix_q, fix_r;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign accept = start_i & ~annul_i;

  div_sign_fix #(.WIDTH(WIDTH)) u_in_fix (
    .x     (opa_i),
    .neg_x (signed_i & opa_i[WIDTH-1]),
    .y     (opb_i),
    .neg_y (signed_i & opb_i[WIDTH-1]),
    .x_fix (abs_a),
    .y_fix (abs_b)
  );

  // Quotient is negative when signs differ; remainder follows the dividend.
  div_sign_fix #(.WIDTH(WIDTH)) u_out_fix (
    .x     (quo),
    .neg_x (sign_a ^ sign_b),
    .y     (rem),
    .neg_y (sign_a),
    .x_fix (fix_q),
    .y_fix (fix_r)
  );

  // Since rem < divisor always holds (or divisor is zero and only WIDTH
  // dividend bits ever enter), a WIDTH+1-bit difference is enough: bit WIDTH
  // set means the trial subtraction went negative.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr};

`ifdef DIV_SHORTCUT_EN
  logic take_short;
  assign take_short = (abs_b == '0) | (abs_b > abs_a);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef DIV_SHORTCUT_EN
          state_nx = take_short ? S_SHORT : S_BUSY;
`else
          state_nx = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        if (!accept) begin
          state_nx = S_IDLE;
        end else if (cnt == LAST_CNT) begin
          state_nx = S_DONE;
        end
      end
`ifdef DIV_SHORTCUT_EN
      S_SHORT: begin
        state_nx = accept ? S_DONE : S_IDLE;
      end
`endif
      S_DONE: begin
        if (annul_i || !hold_i) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            quo    <= abs_a;
            rem    <= '0;
            dvsr   <= abs_b;
            sign_a <= signed_i & opa_i[WIDTH-1];
            sign_b <= signed_i & opb_i[WIDTH-1];
            cnt    <= '0;
          end
        end
        S_BUSY: begin
          rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt + 1'b1;
        end
`ifdef DIV_SHORTCUT_EN
        // Both shortcut cases leave |dividend| as the remainder; only the
        // quotient differs (all-ones for divide-by-zero, else zero).
        S_SHORT: begin
          rem <= quo;
          quo <= (dvsr == '0) ? '1 : '0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // resetn gates stall_o so it drops immediately while reset is asserted.
  assign stall_o  = resetn & accept & (state != S_DONE);
  assign ready_o  = (state == S_DONE);
  assign result_o = ready_o ? {fix_r, fix_q} : '0;

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// ----------------------------------------------------------------------------
// tb_div_iter
// Self-checking bench for div_iter: directed cases plus random divisions
// compared against an arithmetic reference model.
// Optional feature macro: DIV_SHORTCUT_EN (changes expected stall counts).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_div_iter;

  localparam int W = 32;

  logic          clk;
  logic          resetn;
  logic          start_i;
  logic          signed_i;
  logic [W-1:0]  opa_i;
  logic [W-1:0]  opb_i;
  logic          annul_i;
  logic          hold_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          stall_o;

  int n_vec = 0;
  int n_err = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .signed_i (signed_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .annul_i  (annul_i),
    .hold_i   (hold_i),
    .result_o (result_o),
    .ready_o  (ready_o),
    .stall_o  (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {remainder, quotient} from plain integer division with
  // truncation toward zero; divide-by-zero gives all-ones magnitude quotient
  // and the dividend as remainder.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    longint      sa, sb, lq, lr;
    if (!sgn) begin
      if (b == 0) begin
        q = 32'hFFFF_FFFF;
        r = a;
      end else begin
        q = a / b;
        r = a % b;
      end
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
        q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
        r = a;
      end else begin
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
      end
    end
    return {r, q};
  endfunction

  function automatic int exp_stalls(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_SHORTCUT_EN
    logic [31:0] ma, mb;
    ma = (sgn && a[31]) ? (32'd0 - a) : a;
    mb = (sgn && b[31]) ? (32'd0 - b) : b;
    if (mb == 0 || mb > ma) return 2;
`endif
    return 33;
  endfunction

  // Called just after a falling edge with the DUT idle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold_n);
    logic [63:0] exp;
    int          stalls;
    exp      = model(sgn, a, b);
    signed_i = sgn;
    opa_i    = a;
    opb_i    = b;
    start_i  = 1'b1;
    hold_i   = (hold_n > 0);
    #1;
    stalls = 0;
    while (stall_o && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    check("stall_cycles", 64'(stalls), 64'(exp_stalls(sgn, a, b)));
    check("ready", {63'd0, ready_o}, 64'd1);
    check("result", result_o, exp);
    for (int i = 0; i < hold_n; i++) begin
      @(negedge clk);
      check("hold_ready", {63'd0, ready_o}, 64'd1);
      check("hold_stall", {63'd0, stall_o}, 64'd0);
      check("hold_result", result_o, exp);
    end
    hold_i  = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check("idle_ready", {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    resetn   = 1'b0;
    start_i  = 1'b0;
    signed_i = 1'b0;
    opa_i    = '0;
    opb_i    = '0;
    annul_i  = 1'b0;
    hold_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_stall", {63'd0, stall_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_div(1'b0, 32'h0000_0064, 32'h0000_0007, 0);
    check("divu_100_7", 64'h0000_0002_0000_000E, model(1'b0, 32'd100, 32'd7));
    run_div(1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 0);
    check("div_m100_7", 64'hFFFF_FFFE_FFFF_FFF2, model(1'b1, 32'hFFFF_FF9C, 32'd7));
    run_div(1'b0, 32'h0000_0005, 32'h0000_0000, 0);
    run_div(1'b1, 32'h8000_0000, 32'h0000_0000, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'h0000_0003, 32'h0000_0009, 0);
    run_div(1'b0, 32'h1234_5678, 32'h0000_0010, 5);

    // Flush during BUSY iteration 10 (cycle 11 after start).
    signed_i = 1'b0;
    opa_i    = 32'd1000;
    opb_i    = 32'd3;
    start_i  = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    #1;
    check("annul_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    run_div(1'b0, 32'd9, 32'd3, 0);
    check("divu_9_3", 64'h0000_0000_0000_0003, model(1'b0, 32'd9, 32'd3));

    // Reset in the middle of BUSY, start still asserted.
    signed_i = 1'b1;
    opa_i    = 32'hDEAD_BEEF;
    opb_i    = 32'd17;
    start_i  = 1'b1;
    repeat (15) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_stall", {63'd0, stall_o}, 64'd0);
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    resetn  = 1'b1;
    @(negedge clk);
    run_div(1'b1, 32'hDEAD_BEEF, 32'd17, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      logic        sg;
      a  = $urandom;
      b  = $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = {{16{b[15]}}, b[15:0]};
        3: a = 32'h8000_0000;
        4: b = 32'hFFFF_FFFF;
        default: begin end
      endcase
      run_div(sg, a, b, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_iter.md
# div_iter

Iterative radix-2 restoring divider for the EX stage, executing DIV/DIVU into {HI, LO}. It is the producing end of the EX-stage stall handshake: it raises `stall_o` (wired to the hazard unit's `div_stallE`) while a division is in flight. It also accepts the pipeline's flush and downstream-stall signals, so a result is never lost or recomputed.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the result is 2*WIDTH bits.

Ports:
- Clocking and reset (already decided): one clock, `clk`; reset `resetn` is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous active-low reset
- `start_i`  in  1  EX holds a valid DIV/DIVU; held high until the instruction leaves EX
- `signed_i`  in  1  1 = DIV, 0 = DIVU; sampled at start
- `opa_i`  in  WIDTH  dividend (rs); sampled at start
- `opb_i`  in  WIDTH  divisor (rt); sampled at start
- `annul_i`  in  1  exception flush (`flush_exceptionM`); abandons any division
- `hold_i`  in  1  downstream stall (`stallM`); EX cannot advance this cycle
- `result_o`  out  2*WIDTH  {remainder, quotient} → {HI, LO}
- `ready_o`  out  1  `result_o` valid
- `stall_o`  out  1  EX must stall (→ `div_stallE`)

## Operation
- State machine: IDLE, BUSY, SHORT (only with the macro), DONE.
- **IDLE**
  - With `start_i & ~annul_i`, the block latches operands into registers (magnitudes when signed) and latches the signs.
  - It then enters BUSY with the counter at 0, or SHORT if the shortcut applies.
- **BUSY**, one iteration per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor using a WIDTH+1-bit subtractor. If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - The counter runs 0..WIDTH-1. After iteration WIDTH-1 the block enters DONE.
- **DONE**
  - The block applies the sign fix: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - `ready_o`=1 and the result is held.
  - `hold_i`=1 → stay in DONE; no restart, even though `start_i` is still high.
  - `hold_i`=0 → the instruction advances; go to IDLE next cycle.
- **Output logic**
  - `stall_o` = `start_i & ~annul_i & (state != DONE)`. It is combinational, so it is asserted in the start cycle itself.
  - `ready_o` = (state == DONE).
- **Abort**
  - `annul_i`=1 in any state → IDLE next cycle. `stall_o` drops in the same cycle.
  - `start_i`=0 in BUSY or SHORT → IDLE (defensive abort).
- **Divide by zero**: the algorithm naturally yields magnitude quotient all-ones and remainder = |dividend|, then the sign fix is applied. No trap is raised.
- **Reset**: state IDLE, counter 0, `result_o`=0, `ready_o`=0, `stall_o`=0. A reset mid-operation discards the division.

## Timing
- Start in cycle 0 (IDLE, `stall_o`=1).
- BUSY occupies cycles 1..32; DONE is reached in cycle 33.
- `stall_o` is high for 33 cycles (0..32). `ready_o` and the valid result appear in cycle 33, when `stall_o`=0 and EX advances.
- SHORT path: start in cycle 0, SHORT in cycle 1, DONE in cycle 2, for 2 stall cycles.
- `hold_i` during BUSY has no effect on iteration. In DONE it extends residency cycle by cycle.
- Back-to-back divisions: the next start is accepted in the IDLE cycle that follows DONE.

## Configuration
- `DIV_SHORTCUT_EN` defined:
  - At start, if divisor == 0 or |divisor| > |dividend|, the block enters SHORT. SHORT computes the result in one cycle: quotient 0 and remainder = dividend when |b|>|a|; the divide-by-zero values above when b==0.
  - The result is bit-identical to the 32-iteration path.
- Not defined: SHORT does not exist, and every division takes 33 stall cycles.

## Structure
- State encodings, `WIDTH`-derived counter width, and the iteration count go in the shared CPU defines header alongside the existing ALU op codes.
- One sub-module, `div_sign_fix`: combinational absolute value of the operands and the final quotient/remainder negation. It is instantiated twice, once for input and once for output.
- Iteration datapath and FSM live in `div_iter`.

## Test plan
- DIVU 0x0000_0064 / 0x0000_0007 → `stall_o` high 33 cycles (shortcut off); result {0x2, 0xE}; `ready_o` in cycle 33.
- DIV 0xFFFF_FF9C (-100) / 7 → quotient 0xFFFF_FFF2 (-14), remainder 0xFFFF_FFFE (-2).
- DIV 0x8000_0000 / 0 and DIVU 5 / 0:
  - DIVU 5 / 0 → {0x5, 0xFFFF_FFFF}.
  - DIV 0x8000_0000 / 0 → the sign-fixed equivalent.
  - With `DIV_SHORTCUT_EN`, both take 2 stall cycles and give identical results.
- `hold_i`=1 for 5 cycles after DONE → `ready_o` stays 1 and the result is stable, with no second division. Release → IDLE next cycle.
- `annul_i` pulse at BUSY iteration 10 → `stall_o`=0 in the same cycle, IDLE next cycle. A new DIVU 9/3 then gives {0, 3}.
- `resetn` low mid-BUSY → all outputs 0 immediately. After release, a new division completes correctly.
